// File: rtl/rs_bank_if.sv
// Issue/CDB/FU-side signal bundle for the reservation-station bank.
// master = issue stage + CDB + FU side, slave = rs_bank.
interface rs_bank_if #(
  parameter int NUM_RS = 4,
  parameter int DATA_W = 32,
  parameter int TAG_W  = 4,
  parameter int OP_W   = 3,
  parameter int BR_W   = 2
);
  localparam int IDX_W = $clog2(NUM_RS);
  localparam int CNT_W = IDX_W + 1;

  logic              flush;
  logic              alloc_valid;
  logic              alloc_ready;
  logic [OP_W-1:0]   alloc_op;
  logic [BR_W-1:0]   alloc_br;
  logic [TAG_W-1:0]  alloc_rob;
  logic              alloc_rdy_j;
  logic [TAG_W-1:0]  alloc_q_j;
  logic [DATA_W-1:0] alloc_v_j;
  logic              alloc_rdy_k;
  logic [TAG_W-1:0]  alloc_q_k;
  logic [DATA_W-1:0] alloc_v_k;
  logic              cdb_valid;
  logic [TAG_W-1:0]  cdb_tag;
  logic [DATA_W-1:0] cdb_data;
  logic              issue_valid;
  logic              issue_ready;
  logic [OP_W-1:0]   issue_op;
  logic [BR_W-1:0]   issue_br;
  logic [TAG_W-1:0]  issue_rob;
  logic [DATA_W-1:0] issue_v_j;
  logic [DATA_W-1:0] issue_v_k;
  logic [IDX_W-1:0]  issue_idx;
  logic [NUM_RS-1:0] busy_bus;
  logic [CNT_W-1:0]  free_count;

  modport master (
    output flush, alloc_valid, alloc_op, alloc_br, alloc_rob,
           alloc_rdy_j, alloc_q_j, alloc_v_j, alloc_rdy_k, alloc_q_k, alloc_v_k,
           cdb_valid, cdb_tag, cdb_data, issue_ready,
    input  alloc_ready, issue_valid, issue_op, issue_br, issue_rob,
           issue_v_j, issue_v_k, issue_idx, busy_bus, free_count
  );

  modport slave (
    input  flush, alloc_valid, alloc_op, alloc_br, alloc_rob,
           alloc_rdy_j, alloc_q_j, alloc_v_j, alloc_rdy_k, alloc_q_k, alloc_v_k,
           cdb_valid, cdb_tag, cdb_data, issue_ready,
    output alloc_ready, issue_valid, issue_op, issue_br, issue_rob,
           issue_v_j, issue_v_k, issue_idx, busy_bus, free_count
  );
endinterface

// File: rtl/rs_bank.sv
// Reservation-station bank: lowest-free allocate, CDB wakeup, one issue per cycle.
// Define RS_OLDEST_FIRST_EN to select the oldest ready entry via an age matrix.
module rs_bank #(
  parameter int NUM_RS = 4,
  parameter int DATA_W = 32,
  parameter int TAG_W  = 4,
  parameter int OP_W   = 3,
  parameter int BR_W   = 2
) (
  input  logic       clk,
  input  logic       reset_n,
  rs_bank_if.slave   bus
);
  localparam int IDX_W = $clog2(NUM_RS);
  localparam int CNT_W = IDX_W + 1;

  logic [NUM_RS-1:0] valid_q, valid_d, rdy_j_q, rdy_j_d, rdy_k_q, rdy_k_d;
  logic [TAG_W-1:0]  q_j_q [NUM_RS];
  logic [TAG_W-1:0]  q_j_d [NUM_RS];
  logic [TAG_W-1:0]  q_k_q [NUM_RS];
  logic [TAG_W-1:0]  q_k_d [NUM_RS];
  logic [TAG_W-1:0]  rob_q [NUM_RS];
  logic [TAG_W-1:0]  rob_d [NUM_RS];
  logic [DATA_W-1:0] v_j_q [NUM_RS];
  logic [DATA_W-1:0] v_j_d [NUM_RS];
  logic [DATA_W-1:0] v_k_q [NUM_RS];
  logic [DATA_W-1:0] v_k_d [NUM_RS];
  logic [OP_W-1:0]   op_q  [NUM_RS];
  logic [OP_W-1:0]   op_d  [NUM_RS];
  logic [BR_W-1:0]   br_q  [NUM_RS];
  logic [BR_W-1:0]   br_d  [NUM_RS];
`ifdef RS_OLDEST_FIRST_EN
  // older_q[i][j] set means entry i was allocated before entry j
  logic [NUM_RS-1:0] older_q [NUM_RS];
  logic [NUM_RS-1:0] older_d [NUM_RS];
  logic              has_older;
`endif

  logic [NUM_RS-1:0] ready_vec;
  logic              any_free, any_ready, issue_valid, alloc_fire, issue_fire;
  logic              byp_j, byp_k;
  logic [IDX_W-1:0]  alloc_idx, sel_idx;
  logic [CNT_W-1:0]  busy_cnt;

  always_comb begin
    ready_vec = valid_q & rdy_j_q & rdy_k_q;
    any_free  = ~&valid_q;
    any_ready = |ready_vec;
    alloc_idx = '0;
    for (int i = NUM_RS-1; i >= 0; i--) if (!valid_q[i]) alloc_idx = IDX_W'(i);
    sel_idx = '0;
`ifdef RS_OLDEST_FIRST_EN
    has_older = 1'b0;
    for (int i = NUM_RS-1; i >= 0; i--) begin
      has_older = 1'b0;
      for (int j = 0; j < NUM_RS; j++) if (ready_vec[j] && older_q[j][i]) has_older = 1'b1;
      if (ready_vec[i] && !has_older) sel_idx = IDX_W'(i);
    end
`else
    for (int i = NUM_RS-1; i >= 0; i--) if (ready_vec[i]) sel_idx = IDX_W'(i);
`endif
    busy_cnt = '0;
    for (int i = 0; i < NUM_RS; i++) busy_cnt = busy_cnt + CNT_W'(valid_q[i]);
  end

  assign issue_valid     = any_ready && !bus.flush;
  assign alloc_fire      = bus.alloc_valid && any_free;
  assign issue_fire      = issue_valid && bus.issue_ready;
  assign byp_j           = bus.cdb_valid && !bus.alloc_rdy_j && (bus.cdb_tag == bus.alloc_q_j);
  assign byp_k           = bus.cdb_valid && !bus.alloc_rdy_k && (bus.cdb_tag == bus.alloc_q_k);

  assign bus.alloc_ready = any_free;
  assign bus.issue_valid = issue_valid;
  assign bus.issue_op    = issue_valid ? op_q[sel_idx]  : '0;
  assign bus.issue_br    = issue_valid ? br_q[sel_idx]  : '0;
  assign bus.issue_rob   = issue_valid ? rob_q[sel_idx] : '0;
  assign bus.issue_v_j   = issue_valid ? v_j_q[sel_idx] : '0;
  assign bus.issue_v_k   = issue_valid ? v_k_q[sel_idx] : '0;
  assign bus.issue_idx   = issue_valid ? sel_idx : '0;
  assign bus.busy_bus    = valid_q;
  assign bus.free_count  = CNT_W'(NUM_RS) - busy_cnt;

  always_comb begin
    valid_d = valid_q;
    rdy_j_d = rdy_j_q;
    rdy_k_d = rdy_k_q;
    q_j_d   = q_j_q;
    q_k_d   = q_k_q;
    rob_d   = rob_q;
    v_j_d   = v_j_q;
    v_k_d   = v_k_q;
    op_d    = op_q;
    br_d    = br_q;
`ifdef RS_OLDEST_FIRST_EN
    older_d = older_q;
`endif
    for (int i = 0; i < NUM_RS; i++) begin
      if (valid_q[i] && bus.cdb_valid) begin
        if (!rdy_j_q[i] && q_j_q[i] == bus.cdb_tag) begin
          rdy_j_d[i] = 1'b1;
          v_j_d[i]   = bus.cdb_data;
        end
        if (!rdy_k_q[i] && q_k_q[i] == bus.cdb_tag) begin
          rdy_k_d[i] = 1'b1;
          v_k_d[i]   = bus.cdb_data;
        end
      end
    end
    if (issue_fire) valid_d[sel_idx] = 1'b0;
    // the allocated slot was free last cycle, so it never collides with the issued one
    if (alloc_fire) begin
      valid_d[alloc_idx] = 1'b1;
      op_d[alloc_idx]    = bus.alloc_op;
      br_d[alloc_idx]    = bus.alloc_br;
      rob_d[alloc_idx]   = bus.alloc_rob;
      q_j_d[alloc_idx]   = bus.alloc_q_j;
      q_k_d[alloc_idx]   = bus.alloc_q_k;
      rdy_j_d[alloc_idx] = bus.alloc_rdy_j || byp_j;
      rdy_k_d[alloc_idx] = bus.alloc_rdy_k || byp_k;
      v_j_d[alloc_idx]   = byp_j ? bus.cdb_data : bus.alloc_v_j;
      v_k_d[alloc_idx]   = byp_k ? bus.cdb_data : bus.alloc_v_k;
`ifdef RS_OLDEST_FIRST_EN
      older_d[alloc_idx] = '0;
      for (int j = 0; j < NUM_RS; j++) older_d[j][alloc_idx] = valid_q[j];
`endif
    end
    if (bus.flush) begin
      valid_d = '0;
`ifdef RS_OLDEST_FIRST_EN
      for (int j = 0; j < NUM_RS; j++) older_d[j] = '0;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      valid_q <= '0;
      rdy_j_q <= '0;
      rdy_k_q <= '0;
      q_j_q   <= '{default: '0};
      q_k_q   <= '{default: '0};
      rob_q   <= '{default: '0};
      v_j_q   <= '{default: '0};
      v_k_q   <= '{default: '0};
      op_q    <= '{default: '0};
      br_q    <= '{default: '0};
`ifdef RS_OLDEST_FIRST_EN
      older_q <= '{default: '0};
`endif
    end else begin
      valid_q <= valid_d;
      rdy_j_q <= rdy_j_d;
      rdy_k_q <= rdy_k_d;
      q_j_q   <= q_j_d;
      q_k_q   <= q_k_d;
      rob_q   <= rob_d;
      v_j_q   <= v_j_d;
      v_k_q   <= v_k_d;
      op_q    <= op_d;
      br_q    <= br_d;
`ifdef RS_OLDEST_FIRST_EN
      older_q <= older_d;
`endif
    end
  end
endmodule

// File: tb/tb_rs_bank.sv
// Bench for rs_bank: directed vector table, hand sequences, randomized run vs. model.
module tb_rs_bank;
  localparam int NUM_RS = 4;
  localparam int DATA_W = 32;
  localparam int TAG_W  = 4;
  localparam int OP_W   = 3;
  localparam int BR_W   = 2;
  localparam int IDX_W  = $clog2(NUM_RS);

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  rs_bank_if #(.NUM_RS(NUM_RS), .DATA_W(DATA_W), .TAG_W(TAG_W), .OP_W(OP_W), .BR_W(BR_W)) bus ();
  rs_bank #(.NUM_RS(NUM_RS), .DATA_W(DATA_W), .TAG_W(TAG_W), .OP_W(OP_W), .BR_W(BR_W)) dut (
    .clk(clk), .reset_n(reset_n), .bus(bus)
  );

  typedef struct {
    logic fl; logic av; logic [OP_W-1:0] op; logic [BR_W-1:0] br; logic [TAG_W-1:0] rob;
    logic rj; logic [TAG_W-1:0] qj; logic [DATA_W-1:0] vj;
    logic rk; logic [TAG_W-1:0] qk; logic [DATA_W-1:0] vk;
    logic cv; logic [TAG_W-1:0] ct; logic [DATA_W-1:0] cd; logic ir;
    logic e_ar; logic e_iv; logic [TAG_W-1:0] e_rob; logic [DATA_W-1:0] e_vj; logic [DATA_W-1:0] e_vk;
    logic [NUM_RS-1:0] e_busy; logic [2:0] e_fc;
  } vec_t;

  typedef struct {
    bit v; bit rj; bit rk;
    logic [TAG_W-1:0] qj; logic [TAG_W-1:0] qk; logic [TAG_W-1:0] rob;
    logic [DATA_W-1:0] vj; logic [DATA_W-1:0] vk;
    logic [OP_W-1:0] op; logic [BR_W-1:0] br;
    int unsigned seq;
  } ment_t;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t nop();
    vec_t v;
    v = '{default: '0};
    return v;
  endfunction

  function automatic vec_t alc(input int rob, input int rj, input int qj, input logic [31:0] vj,
                               input int rk, input int qk, input logic [31:0] vk);
    vec_t v;
    v = nop();
    v.av = 1'b1; v.rob = TAG_W'(rob); v.op = OP_W'(rob + 1); v.br = BR_W'(rob);
    v.rj = rj[0]; v.qj = TAG_W'(qj); v.vj = vj;
    v.rk = rk[0]; v.qk = TAG_W'(qk); v.vk = vk;
    return v;
  endfunction

  function automatic vec_t cdb(input vec_t vi, input int tag, input logic [31:0] data);
    vec_t v;
    v = vi; v.cv = 1'b1; v.ct = TAG_W'(tag); v.cd = data;
    return v;
  endfunction

  function automatic vec_t iss(input vec_t vi);
    vec_t v;
    v = vi; v.ir = 1'b1;
    return v;
  endfunction

  function automatic vec_t flu(input vec_t vi);
    vec_t v;
    v = vi; v.fl = 1'b1;
    return v;
  endfunction

  function automatic vec_t ex(input vec_t vi, input int ar, input int iv, input int rob,
                              input logic [31:0] vj, input logic [31:0] vk, input int busy, input int fc);
    vec_t v;
    v = vi;
    v.e_ar = ar[0]; v.e_iv = iv[0]; v.e_rob = TAG_W'(rob); v.e_vj = vj; v.e_vk = vk;
    v.e_busy = NUM_RS'(busy); v.e_fc = 3'(fc);
    return v;
  endfunction

  task automatic drive(input vec_t v);
    bus.flush = v.fl; bus.alloc_valid = v.av; bus.alloc_op = v.op; bus.alloc_br = v.br;
    bus.alloc_rob = v.rob; bus.alloc_rdy_j = v.rj; bus.alloc_q_j = v.qj; bus.alloc_v_j = v.vj;
    bus.alloc_rdy_k = v.rk; bus.alloc_q_k = v.qk; bus.alloc_v_k = v.vk;
    bus.cdb_valid = v.cv; bus.cdb_tag = v.ct; bus.cdb_data = v.cd; bus.issue_ready = v.ir;
  endtask

  task automatic chk_row(input string tag, input vec_t v);
    chk({tag, ".alloc_ready"}, 128'(bus.alloc_ready), 128'(v.e_ar));
    chk({tag, ".issue_valid"}, 128'(bus.issue_valid), 128'(v.e_iv));
    chk({tag, ".issue_rob"},   128'(bus.issue_rob),   128'(v.e_rob));
    chk({tag, ".issue_v_j"},   128'(bus.issue_v_j),   128'(v.e_vj));
    chk({tag, ".issue_v_k"},   128'(bus.issue_v_k),   128'(v.e_vk));
    chk({tag, ".busy_bus"},    128'(bus.busy_bus),    128'(v.e_busy));
    chk({tag, ".free_count"},  128'(bus.free_count),  128'(v.e_fc));
  endtask

  task automatic apply(input vec_t v);
    drive(v);
    @(negedge clk);
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  vec_t tbl[$];
  ment_t m [NUM_RS];
  ment_t nm [NUM_RS];
  int unsigned seq_ctr;
  int first_rob, second_rob;

  initial begin
    // each row: inputs for one cycle, outputs expected in that same cycle (before the edge)
    tbl.push_back(ex(nop(),                                   1, 0, 0, 0, 0, 4'b0000, 4));
    tbl.push_back(ex(alc(5, 1, 0, 10, 1, 0, 20),              1, 0, 0, 0, 0, 4'b0000, 4));
    tbl.push_back(ex(iss(nop()),                              1, 1, 5, 10, 20, 4'b0001, 3));
    tbl.push_back(ex(nop(),                                   1, 0, 0, 0, 0, 4'b0000, 4));
    tbl.push_back(ex(alc(3, 0, 7, 0, 1, 0, 2),                1, 0, 0, 0, 0, 4'b0000, 4));
    tbl.push_back(ex(nop(),                                   1, 0, 0, 0, 0, 4'b0001, 3));
    tbl.push_back(ex(cdb(nop(), 7, 32'hDEAD),                 1, 0, 0, 0, 0, 4'b0001, 3));
    tbl.push_back(ex(iss(nop()),                              1, 1, 3, 32'hDEAD, 2, 4'b0001, 3));
    tbl.push_back(ex(nop(),                                   1, 0, 0, 0, 0, 4'b0000, 4));
    tbl.push_back(ex(cdb(alc(6, 1, 0, 1, 0, 9, 0), 9, 42),    1, 0, 0, 0, 0, 4'b0000, 4));
    tbl.push_back(ex(iss(nop()),                              1, 1, 6, 1, 42, 4'b0001, 3));
    tbl.push_back(ex(nop(),                                   1, 0, 0, 0, 0, 4'b0000, 4));
    tbl.push_back(ex(alc(1, 0, 8, 0, 0, 8, 0),                1, 0, 0, 0, 0, 4'b0000, 4));
    tbl.push_back(ex(alc(2, 0, 8, 0, 0, 8, 0),                1, 0, 0, 0, 0, 4'b0001, 3));
    tbl.push_back(ex(alc(3, 0, 8, 0, 0, 8, 0),                1, 0, 0, 0, 0, 4'b0011, 2));
    tbl.push_back(ex(alc(4, 0, 8, 0, 0, 8, 0),                1, 0, 0, 0, 0, 4'b0111, 1));
    tbl.push_back(ex(alc(10, 1, 0, 0, 1, 0, 0),               0, 0, 0, 0, 0, 4'b1111, 0));
    tbl.push_back(ex(cdb(nop(), 8, 5),                        0, 0, 0, 0, 0, 4'b1111, 0));
    tbl.push_back(ex(iss(nop()),                              0, 1, 1, 5, 5, 4'b1111, 0));
    tbl.push_back(ex(nop(),                                   1, 1, 2, 5, 5, 4'b1110, 1));
    tbl.push_back(ex(flu(cdb(alc(12, 1, 0, 3, 1, 0, 4), 8, 9)), 1, 0, 0, 0, 0, 4'b1110, 1));
    tbl.push_back(ex(nop(),                                   1, 0, 0, 0, 0, 4'b0000, 4));

    drive(nop());
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;

    for (int k = 0; k < tbl.size(); k++) begin
      apply(tbl[k]);
      chk_row($sformatf("vec%0d", k), tbl[k]);
      adv();
    end

    // age ordering: rob1 issues, rob3 reuses idx0 behind rob2 in idx1
`ifdef RS_OLDEST_FIRST_EN
    first_rob = 2; second_rob = 3;
`else
    first_rob = 3; second_rob = 2;
`endif
    apply(alc(1, 1, 0, 11, 1, 0, 12));                 adv();
    apply(iss(alc(2, 0, 12, 0, 1, 0, 22)));
    chk("age.first_issue_rob", 128'(bus.issue_rob), 128'(1));
    chk("age.first_issue_idx", 128'(bus.issue_idx), 128'(0));
    adv();
    apply(alc(3, 0, 13, 0, 1, 0, 33));
    chk("age.busy_after_issue", 128'(bus.busy_bus), 128'(4'b0010));
    adv();
    apply(cdb(nop(), 12, 32'h120));
    chk("age.busy_two", 128'(bus.busy_bus), 128'(4'b0011));
    chk("age.none_ready", 128'(bus.issue_valid), 128'(0));
    adv();
    apply(cdb(nop(), 13, 32'h130));
    chk("age.only_rob2_ready", 128'(bus.issue_rob), 128'(2));
    adv();
    apply(iss(nop()));
    chk("age.order_first", 128'(bus.issue_rob), 128'(first_rob));
    adv();
    apply(iss(nop()));
    chk("age.order_second", 128'(bus.issue_rob), 128'(second_rob));
    adv();
    apply(nop());
    chk("age.drained", 128'(bus.busy_bus), 128'(0));
    adv();

    // reset in the middle of operation, then tag 0 as an ordinary producer tag
    apply(alc(7, 1, 0, 70, 1, 0, 71));                 adv();
    apply(alc(8, 0, 5, 0, 1, 0, 81));                  adv();
    reset_n = 1'b0;
    apply(alc(9, 1, 0, 90, 1, 0, 91));
    chk("rst.pre_busy", 128'(bus.busy_bus), 128'(4'b0011));
    adv();
    reset_n = 1'b1;
    apply(ex(nop(), 1, 0, 0, 0, 0, 4'b0000, 4));
    chk_row("rst", ex(nop(), 1, 0, 0, 0, 0, 4'b0000, 4));
    chk("rst.issue_op_zero", 128'({bus.issue_op, bus.issue_br, bus.issue_idx}), 128'(0));
    adv();
    apply(alc(11, 0, 0, 0, 1, 0, 5));                  adv();
    apply(cdb(nop(), 0, 77));
    chk("tag0.not_ready", 128'(bus.issue_valid), 128'(0));
    adv();
    apply(iss(nop()));
    chk("tag0.woken_v_j", 128'({bus.issue_valid, bus.issue_rob, bus.issue_v_j}), 128'({1'b1, 4'd11, 32'd77}));
    adv();

    // randomized run against a sequence-number model
    reset_n = 1'b0;
    apply(nop());
    adv();
    reset_n = 1'b1;
    for (int i = 0; i < NUM_RS; i++) m[i] = '{default: '0};
    seq_ctr = 0;

    for (int c = 0; c < 3000; c++) begin
      vec_t r;
      bit rst_now;
      int nfree, sel, slot;
      bit exp_iv;
      logic [127:0] e_f, a_f;
      r = nop();
      rst_now  = ($urandom_range(0, 199) != 0);
      r.fl = ($urandom_range(0, 39) == 0);
      r.av = ($urandom_range(0, 9) < 6);
      r.op = OP_W'($urandom); r.br = BR_W'($urandom); r.rob = TAG_W'($urandom);
      r.rj = $urandom_range(0, 1) != 0; r.qj = TAG_W'($urandom_range(0, 3)); r.vj = $urandom;
      r.rk = $urandom_range(0, 1) != 0; r.qk = TAG_W'($urandom_range(0, 3)); r.vk = $urandom;
      r.cv = ($urandom_range(0, 9) < 4); r.ct = TAG_W'($urandom_range(0, 3)); r.cd = $urandom;
      r.ir = ($urandom_range(0, 9) < 5);
      drive(r);
      reset_n = rst_now;
      @(negedge clk);

      nfree = 0; sel = -1;
      for (int i = 0; i < NUM_RS; i++) begin
        if (!m[i].v) nfree++;
        if (m[i].v && m[i].rj && m[i].rk) begin
`ifdef RS_OLDEST_FIRST_EN
          if (sel < 0 || m[i].seq < m[sel].seq) sel = i;
`else
          if (sel < 0) sel = i;
`endif
        end
      end
      exp_iv = (sel >= 0) && !r.fl;
      e_f = '0;
      if (exp_iv) e_f = 128'({m[sel].op, m[sel].br, m[sel].rob, m[sel].vj, m[sel].vk, IDX_W'(sel)});
      a_f = 128'({bus.issue_op, bus.issue_br, bus.issue_rob, bus.issue_v_j, bus.issue_v_k, bus.issue_idx});
      chk($sformatf("rnd%0d.alloc_ready", c), 128'(bus.alloc_ready), 128'(nfree > 0));
      chk($sformatf("rnd%0d.issue_valid", c), 128'(bus.issue_valid), 128'(exp_iv));
      chk($sformatf("rnd%0d.issue_fields", c), a_f, e_f);
      chk($sformatf("rnd%0d.free_count", c), 128'(bus.free_count), 128'(nfree));
      chk($sformatf("rnd%0d.busy_bus", c), 128'(bus.busy_bus),
          128'({m[3].v, m[2].v, m[1].v, m[0].v}));

      nm = m;
      if (!rst_now) begin
        for (int i = 0; i < NUM_RS; i++) nm[i] = '{default: '0};
      end else if (r.fl) begin
        for (int i = 0; i < NUM_RS; i++) nm[i].v = 1'b0;
      end else begin
        for (int i = 0; i < NUM_RS; i++) begin
          if (m[i].v && r.cv && !m[i].rj && m[i].qj == r.ct) begin nm[i].rj = 1'b1; nm[i].vj = r.cd; end
          if (m[i].v && r.cv && !m[i].rk && m[i].qk == r.ct) begin nm[i].rk = 1'b1; nm[i].vk = r.cd; end
        end
        if (exp_iv && r.ir) nm[sel].v = 1'b0;
        if (r.av && nfree > 0) begin
          slot = -1;
          for (int i = 0; i < NUM_RS; i++) if (!m[i].v && slot < 0) slot = i;
          nm[slot].v   = 1'b1;
          nm[slot].op  = r.op; nm[slot].br = r.br; nm[slot].rob = r.rob;
          nm[slot].qj  = r.qj; nm[slot].qk = r.qk;
          nm[slot].rj  = r.rj || (r.cv && r.ct == r.qj);
          nm[slot].rk  = r.rk || (r.cv && r.ct == r.qk);
          nm[slot].vj  = (!r.rj && r.cv && r.ct == r.qj) ? r.cd : r.vj;
          nm[slot].vk  = (!r.rk && r.cv && r.ct == r.qk) ? r.cd : r.vk;
          nm[slot].seq = seq_ctr;
          seq_ctr++;
        end
      end
      adv();
      m = nm;
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/rs_bank.md
Name: rs_bank

Overview:
- Parametrised reservation-station bank holding NUM_RS entries between issue and the functional-unit scheduler.
- Allocates incoming instructions to free entries and snoops the CDB to capture pending operands.
- Selects one ready entry per cycle and hands it to the FU over a valid/ready handshake.
- Frees the entry on handshake and clears all entries on a flush (mispredict).

Parameters:
- NUM_RS, 4, number of entries (2..16).
- DATA_W, 32, operand and CDB result width.
- TAG_W, 4, ROB tag width.
- OP_W, 3, ALU opcode width.
- BR_W, 2, branch-type width.

Ports:
- clk  in  1  clock.
- reset_n  in  1  synchronous active-low reset.
- flush  in  1  mispredict flush; clears all entries.
- alloc_valid  in  1  issue stage presents an instruction.
- alloc_ready  out  1  at least one entry is free.
- alloc_op  in  OP_W  ALU opcode.
- alloc_br  in  BR_W  branch type.
- alloc_rob  in  TAG_W  destination ROB entry.
- alloc_rdy_j  in  1  operand j value valid.
- alloc_q_j  in  TAG_W  producer tag for j.
- alloc_v_j  in  DATA_W  value for j.
- alloc_rdy_k  in  1  operand k value valid.
- alloc_q_k  in  TAG_W  producer tag for k.
- alloc_v_k  in  DATA_W  value for k.
- cdb_valid  in  1  CDB broadcast valid.
- cdb_tag  in  TAG_W  CDB ROB tag.
- cdb_data  in  DATA_W  CDB result.
- issue_valid  out  1  a ready entry is presented.
- issue_ready  in  1  FU accepts.
- issue_op  out  OP_W  opcode of the presented entry.
- issue_br  out  BR_W  branch type of the presented entry.
- issue_rob  out  TAG_W  ROB entry of the presented entry.
- issue_v_j  out  DATA_W  operand j value.
- issue_v_k  out  DATA_W  operand k value.
- issue_idx  out  $clog2(NUM_RS)  index of the presented entry.
- busy_bus  out  NUM_RS  per-entry valid bits.
- free_count  out  $clog2(NUM_RS)+1  number of free entries.

Behaviour:
- Reset (reset_n=0 at posedge): all entry valid and ready bits 0. Outputs: alloc_ready=1, issue_valid=0, all issue_* fields 0, busy_bus=0, free_count=NUM_RS.
- Entry state: valid, rdy_j, rdy_k, q_j, q_k, v_j, v_k, op, br, rob.
- Operand readiness is tracked by explicit rdy bits. Tag 0 is a legal ROB tag and carries no special meaning.
- Allocation:
  - Fires when alloc_valid && alloc_ready.
  - Writes the lowest-index free entry at the posedge.
  - alloc_ready = any entry invalid, computed from registered valid bits only. An entry freed by issue in the same cycle is not reusable until the next cycle.
- Alloc-time CDB bypass: if cdb_valid and cdb_tag == alloc_q_j with alloc_rdy_j=0, the entry stores rdy_j=1 and v_j=cdb_data. Same for operand k.
- CDB snoop: every cycle, each valid entry with rdy_x=0 and q_x==cdb_tag (cdb_valid=1) sets rdy_x=1 and v_x=cdb_data at the posedge. Both operands may wake in the same cycle.
- Ready definition: entry ready = valid && rdy_j && rdy_k, all registered.
  - An entry woken by the CDB at edge N can issue in the cycle after edge N.
  - An entry allocated with both operands ready at edge N can issue in the cycle after edge N.
- Select:
  - issue_valid = any entry ready and !flush.
  - The presented entry is the lowest-index ready entry.
  - issue_* fields are combinational from that entry, and 0 when issue_valid=0.
- Issue handshake: on issue_valid && issue_ready, the selected entry's valid clears at the posedge. The presented entry must not change while issue_valid=1 && issue_ready=0 unless a lower-index entry becomes ready.
- Flush: at the posedge, all valid bits clear. Flush has priority over allocate, issue and CDB updates; no allocation is recorded that cycle.
- Reset mid-operation behaves like flush and also clears all stored fields to 0.
- Full: free_count=0, alloc_ready=0; alloc_valid is ignored.
- Empty: issue_valid=0.
- free_count and busy_bus reflect registered state, updated one cycle after alloc/issue.

Optional Feature:
- Macro: RS_OLDEST_FIRST_EN.
- Defined: an NUM_RS x NUM_RS age matrix is maintained.
  - On allocation, the new entry is marked younger than every currently valid entry.
  - Select presents the oldest ready entry instead of the lowest-index one.
  - Flush/reset clear the matrix.
- Undefined: no matrix; lowest-index-ready select.

Test Plan:
- Reset, then alloc rob=5, both rdy=1, v_j=10, v_k=20 -> next cycle issue_valid=1, issue_rob=5, issue_v_j=10, issue_v_k=20; with issue_ready=1 -> busy_bus=0000, free_count=4.
- Alloc rob=3 with rdy_j=0 q_j=7; two cycles later cdb_valid tag=7 data=0xDEAD -> issue_valid rises the cycle after that CDB edge, issue_v_j=0xDEAD.
- Alloc with q_k=9 while cdb_valid tag=9 data=42 in the same cycle -> entry stored rdy_k=1, v_k=42, issuable next cycle.
- Fill all 4 entries with unready operands -> alloc_ready=0, free_count=0; a 5th alloc_valid is dropped and busy_bus=1111 is unchanged.
- 3 valid entries, assert flush together with alloc_valid and a CDB hit -> next cycle busy_bus=0000, issue_valid=0, free_count=4.
- With RS_OLDEST_FIRST_EN: alloc to idx0 (rob 1), idx1 (rob 2), issue idx0, alloc rob 3 into idx0, make all ready -> issue order rob 2 then rob 3. Without the macro -> rob 3 then rob 2.
